axis_gemv_fixed_mac_pipe: RTL and testbench
===========================================

Name: axis_gemv_fixed_mac_pipe

Overview:
Pipelined, parametrised signed fixed-point multiply-accumulate engine. It is the successor of the single-cycle combinational multiplier in the GEMV datapath. It accepts a stream of (a, b, last) beats, multiplies them through a registered multiplier of MUL_STAGES stages, and accumulates. At each last beat it emits one rounded, saturated dot-product result. It sits between the vector/row fetch logic and the AXI-Stream output packer of axis_gemv_fixed.

Parameters:
A_WIDTH, 25, signed width of operand a
B_WIDTH, 25, signed width of operand b
ACC_WIDTH, 56, signed accumulator width; must be >= A_WIDTH+B_WIDTH
OUT_WIDTH, 32, signed result width
FRAC_SHIFT, 16, right-shift applied to the accumulator before output; 0 means no rounding
MUL_STAGES, 2, multiplier register stages; must be >= 1

Ports:
ap_clk  in  1  clock; all state on rising edge
ap_rst_n  in  1  asynchronous active-low reset
s_valid  in  1  input beat valid
s_ready  out  1  input beat ready
s_a  in  A_WIDTH  signed operand a
s_b  in  B_WIDTH  signed operand b
s_last  in  1  final beat of current dot product
m_valid  out  1  result valid
m_ready  in  1  result ready
m_data  out  OUT_WIDTH  signed rounded/saturated result
m_sat  out  1  result was clipped; qualified by m_valid

Behaviour:
- Reset (async assert, sync release): m_valid=0, m_data=0, m_sat=0, all stage valids=0, acc=0, first=1. s_ready is combinational and equals 1 after reset.
- Advance enable: adv = !m_valid || m_ready. s_ready = adv.
- Global stall: all pipeline stages and the accumulator hold when adv=0.
- Accept: a beat is taken when s_valid && s_ready.
- Multiply: product is exactly A_WIDTH+B_WIDTH bits, signed*signed. Bubbles (stage valid=0) propagate and never touch the accumulator.
- Accumulate: when the final multiplier stage holds a valid product and adv=1:
  - sum = (first ? 0 : acc) + sext(product, ACC_WIDTH).
  - If the beat is not last: acc <= sum, first <= 0.
  - If the beat is last: load the output register with round_sat(sum), set m_valid=1, acc <= 0, first <= 1.
- Accumulator overflow wraps in two's complement. Sizing ACC_WIDTH to prevent this is the integrator's job.
- round_sat(x):
  - If FRAC_SHIFT > 0: r = (x + 2^(FRAC_SHIFT-1)) >>> FRAC_SHIFT. This is round-half-up toward +inf; the add is done one bit wider and cannot overflow.
  - Clip r to [-2^(OUT_WIDTH-1), 2^(OUT_WIDTH-1)-1]. m_sat=1 iff clipped.
- Latency: a last beat accepted at cycle t gives m_valid=1 at cycle t+MUL_STAGES+1, with no stall.
- Throughput: 1 beat/cycle while adv=1. A single-beat vector is legal (first and last on the same beat).
- Output hold: m_data and m_sat stay stable while m_valid && !m_ready.
- Same-cycle events: m_ready=1 together with a new last result arriving reloads the register, so m_valid stays 1 with no bubble. m_ready=1 with no new result clears m_valid.
- Reset mid-vector: the partial sum and all in-flight beats are discarded. The first beat after release starts a new vector.
- s_a, s_b and s_last are don't-care when s_valid=0.

Decomposition:
- Package axis_gemv_fixed_pkg holds:
  - default width constants: A/B/ACC/OUT widths, FRAC_SHIFT
  - function round_sat(value, shift, out_width)
  - function sat_flag
- Sub-module axis_gemv_fixed_mul_pipe holds the parametrised MUL_STAGES-deep signed multiplier with enable (adv) and a valid/last sideband. The accumulator, rounding and output register stay in the top module.

Test Plan (defaults: FRAC_SHIFT=16, MUL_STAGES=2):
- Single beat: a=65536, b=65536, last=1, m_ready=1 -> m_data=65536, m_sat=0, m_valid exactly 3 cycles after accept.
- 4-beat vector: a=65536,131072,196608,262144; b=65536; last on beat 4 -> one result, m_data=655360. Back-to-back second vector with a=-65536 (x4), b=65536 -> m_data=-262144 on the very next result cycle.
- Rounding: a=3, b=32768 -> m_data=2. a=-3, b=32768 -> m_data=-1. a=1, b=32767 -> m_data=0.
- Saturation: 4 beats of a=b=16777215 -> m_data=0x7FFFFFFF, m_sat=1. One beat of a=-16777216, b=16777215 -> m_data=0x80000000, m_sat=1.
- Backpressure: continuous vectors of length 1, m_ready held 0 for 10 cycles -> s_ready=0 within the same cycle as m_valid&&!m_ready, m_data stable, no result lost or reordered after release; randomised m_ready scoreboarded against a reference model.
- Reset mid-vector: pulse ap_rst_n low after beat 2 of 4 -> m_valid=0 immediately. A following 1-beat vector a=b=65536 yields 65536, with no residue from the discarded partial sum.

Source files
------------

// File: rtl/axis_gemv_fixed_pkg.sv
// Package for the GEMV fixed-point MAC datapath.
// Holds the default widths and the rounding/saturation helpers used by
// axis_gemv_fixed_mac_pipe. The helpers operate on a wide signed type
// (calc_t) so a single function body serves any accumulator width up to
// CALC_W-2 bits without overflowing the rounding add.
package axis_gemv_fixed_pkg;

    localparam int DEF_A_WIDTH    = 25;
    localparam int DEF_B_WIDTH    = 25;
    localparam int DEF_ACC_WIDTH  = 56;
    localparam int DEF_OUT_WIDTH  = 32;
    localparam int DEF_FRAC_SHIFT = 16;
    localparam int DEF_MUL_STAGES = 2;

    localparam int CALC_W = 128;
    typedef logic signed [CALC_W-1:0] calc_t;

    // Round-half-up (toward +inf) arithmetic right shift; shift=0 is a pass-through.
    function automatic calc_t round_shift(input calc_t value, input int shift);
        calc_t bias;
        bias = '0;
        if (shift > 0) begin
            bias = calc_t'(1) <<< (shift - 1);
        end
        return (value + bias) >>> shift;
    endfunction

    function automatic calc_t out_max(input int out_width);
        return (calc_t'(1) <<< (out_width - 1)) - calc_t'(1);
    endfunction

    function automatic calc_t out_min(input int out_width);
        return -(calc_t'(1) <<< (out_width - 1));
    endfunction

    // Rounded value clipped into the signed out_width range.
    function automatic calc_t round_sat(input calc_t value, input int shift, input int out_width);
        calc_t r;
        r = round_shift(value, shift);
        if (r > out_max(out_width)) begin
            r = out_max(out_width);
        end else if (r < out_min(out_width)) begin
            r = out_min(out_width);
        end
        return r;
    endfunction

    // High when round_sat would have to clip the rounded value.
    function automatic logic sat_flag(input calc_t value, input int shift, input int out_width);
        calc_t r;
        r = round_shift(value, shift);
        return (r > out_max(out_width)) || (r < out_min(out_width));
    endfunction

endpackage

// File: rtl/axis_gemv_fixed_mul_pipe.sv
// MUL_STAGES-deep registered signed multiplier with valid/last sideband.
// Ports:
//   clk, rst_n          clock, async active-low reset
//   en                  global advance; all stages hold when low
//   in_valid, in_last   beat qualifier and end-of-vector flag
//   a, b                signed operands
//   out_valid, out_last sideband aligned with product
//   product             exact A_WIDTH+B_WIDTH signed product
module axis_gemv_fixed_mul_pipe
    import axis_gemv_fixed_pkg::*;
#(
    parameter int A_WIDTH    = DEF_A_WIDTH,
    parameter int B_WIDTH    = DEF_B_WIDTH,
    parameter int MUL_STAGES = DEF_MUL_STAGES
) (
    input  logic                              clk,
    input  logic                              rst_n,
    input  logic                              en,
    input  logic                              in_valid,
    input  logic                              in_last,
    input  logic signed [A_WIDTH-1:0]         a,
    input  logic signed [B_WIDTH-1:0]         b,
    output logic                              out_valid,
    output logic                              out_last,
    output logic signed [A_WIDTH+B_WIDTH-1:0] product
);

    localparam int P_WIDTH = A_WIDTH + B_WIDTH;

    logic signed [P_WIDTH-1:0] product_c;
    logic signed [P_WIDTH-1:0] prod_q  [MUL_STAGES];
    logic                      valid_q [MUL_STAGES];
    logic                      last_q  [MUL_STAGES];

    // Sign-extend both operands to the full product width so the multiply is exact.
    assign product_c = P_WIDTH'(a) * P_WIDTH'(b);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < MUL_STAGES; i++) begin
                prod_q[i]  <= '0;
                valid_q[i] <= 1'b0;
                last_q[i]  <= 1'b0;
            end
        end else if (en) begin
            prod_q[0]  <= product_c;
            valid_q[0] <= in_valid;
            last_q[0]  <= in_last;
            for (int i = 1; i < MUL_STAGES; i++) begin
                prod_q[i]  <= prod_q[i-1];
                valid_q[i] <= valid_q[i-1];
                last_q[i]  <= last_q[i-1];
            end
        end
    end

    assign out_valid = valid_q[MUL_STAGES-1];
    assign out_last  = last_q[MUL_STAGES-1];
    assign product   = prod_q[MUL_STAGES-1];

endmodule

// File: rtl/axis_gemv_fixed_mac_pipe.sv
// Pipelined signed fixed-point multiply-accumulate for the GEMV datapath.
// Accepts (a, b, last) beats, multiplies through a registered pipeline,
// accumulates, and emits one rounded/saturated dot product per last beat.
// Ports:
//   ap_clk, ap_rst_n            clock, async active-low reset
//   s_valid/s_ready             input beat handshake
//   s_a, s_b, s_last            operands and end-of-vector flag
//   m_valid/m_ready             result handshake
//   m_data                      rounded, saturated result
//   m_sat                       result was clipped (qualified by m_valid)
module axis_gemv_fixed_mac_pipe
    import axis_gemv_fixed_pkg::*;
#(
    parameter int A_WIDTH    = DEF_A_WIDTH,
    parameter int B_WIDTH    = DEF_B_WIDTH,
    parameter int ACC_WIDTH  = DEF_ACC_WIDTH,
    parameter int OUT_WIDTH  = DEF_OUT_WIDTH,
    parameter int FRAC_SHIFT = DEF_FRAC_SHIFT,
    parameter int MUL_STAGES = DEF_MUL_STAGES
) (
    input  logic                        ap_clk,
    input  logic                        ap_rst_n,
    input  logic                        s_valid,
    output logic                        s_ready,
    input  logic signed [A_WIDTH-1:0]   s_a,
    input  logic signed [B_WIDTH-1:0]   s_b,
    input  logic                        s_last,
    output logic                        m_valid,
    input  logic                        m_ready,
    output logic signed [OUT_WIDTH-1:0] m_data,
    output logic                        m_sat
);

    localparam int P_WIDTH = A_WIDTH + B_WIDTH;

    logic                        adv;
    logic                        mul_valid;
    logic                        mul_last;
    logic signed [P_WIDTH-1:0]   mul_product;
    logic signed [ACC_WIDTH-1:0] acc;
    logic                        first;
    logic signed [ACC_WIDTH-1:0] acc_base;
    logic signed [ACC_WIDTH-1:0] sum;
    logic signed [OUT_WIDTH-1:0] rounded;
    logic                        clipped;

    // One advance enable stalls the whole pipe; the output register is the
    // only point of backpressure.
    assign adv     = !m_valid || m_ready;
    assign s_ready = adv;

    axis_gemv_fixed_mul_pipe #(
        .A_WIDTH    (A_WIDTH),
        .B_WIDTH    (B_WIDTH),
        .MUL_STAGES (MUL_STAGES)
    ) u_mul (
        .clk       (ap_clk),
        .rst_n     (ap_rst_n),
        .en        (adv),
        .in_valid  (s_valid),
        .in_last   (s_last),
        .a         (s_a),
        .b         (s_b),
        .out_valid (mul_valid),
        .out_last  (mul_last),
        .product   (mul_product)
    );

    // 'first' substitutes zero for the accumulator so a vector can start
    // back-to-back with the previous one without a clear cycle.
    assign acc_base = first ? '0 : acc;
    assign sum      = acc_base + ACC_WIDTH'(mul_product);
    assign rounded  = OUT_WIDTH'(round_sat(calc_t'(sum), FRAC_SHIFT, OUT_WIDTH));
    assign clipped  = sat_flag(calc_t'(sum), FRAC_SHIFT, OUT_WIDTH);

    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            acc     <= '0;
            first   <= 1'b1;
            m_valid <= 1'b0;
            m_data  <= '0;
            m_sat   <= 1'b0;
        end else if (adv) begin
            // With adv high the current result (if any) is being consumed,
            // so m_valid follows whether a new result lands this cycle.
            m_valid <= mul_valid && mul_last;
            if (mul_valid) begin
                if (mul_last) begin
                    m_data <= rounded;
                    m_sat  <= clipped;
                    acc    <= '0;
                    first  <= 1'b1;
                end else begin
                    acc    <= sum;
                    first  <= 1'b0;
                end
            end
        end
    end

endmodule

// File: tb/tb_axis_gemv_fixed_mac_pipe.sv
module tb_axis_gemv_fixed_mac_pipe;

    logic               ap_clk = 1'b0;
    logic               ap_rst_n = 1'b0;
    logic               s_valid = 1'b0;
    logic               s_ready;
    logic signed [24:0] s_a = '0;
    logic signed [24:0] s_b = '0;
    logic               s_last = 1'b0;
    logic               m_valid;
    logic               m_ready = 1'b1;
    logic signed [31:0] m_data;
    logic               m_sat;

    typedef struct {
        longint data;
        bit     sat;
    } exp_t;

    exp_t   sb[$];
    int     total = 0;
    int     bad = 0;
    int     rdy_mode = 0;   // 0: always ready, 1: random, 2: never ready
    bit     hold_v = 1'b0;
    longint hold_data = 0;
    bit     hold_sat = 1'b0;

    axis_gemv_fixed_mac_pipe dut (
        .ap_clk   (ap_clk),
        .ap_rst_n (ap_rst_n),
        .s_valid  (s_valid),
        .s_ready  (s_ready),
        .s_a      (s_a),
        .s_b      (s_b),
        .s_last   (s_last),
        .m_valid  (m_valid),
        .m_ready  (m_ready),
        .m_data   (m_data),
        .m_sat    (m_sat)
    );

    always #5 ap_clk = ~ap_clk;

    task automatic check(input string name, input longint act, input longint exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic push_exp(input longint data, input bit sat);
        exp_t e;
        e.data = data;
        e.sat  = sat;
        sb.push_back(e);
    endtask

    // Drive one beat, wait until it is taken (bounded), then drop s_valid.
    // Returns at posedge+1 so back-to-back calls keep s_valid contiguous.
    task automatic send_beat(input longint a, input longint b, input bit last);
        int n;
        bit taken;
        n = 0;
        taken = 1'b0;
        s_valid = 1'b1;
        s_a = a[24:0];
        s_b = b[24:0];
        s_last = last;
        while (!taken && n < 200) begin
            @(negedge ap_clk);
            taken = s_ready;
            @(posedge ap_clk);
            #1;
            n++;
        end
        s_valid = 1'b0;
        s_last = 1'b0;
        check("beat_accepted", longint'(taken), 1);
    endtask

    // m_ready driver
    initial begin
        forever begin
            @(posedge ap_clk);
            #1;
            case (rdy_mode)
                0:       m_ready = 1'b1;
                1:       m_ready = ($urandom_range(0, 1) == 1);
                default: m_ready = 1'b0;
            endcase
        end
    end

    // Monitor: scoreboard pop on every transfer, hold and stall checks.
    always @(negedge ap_clk) begin
        if (!ap_rst_n) begin
            hold_v = 1'b0;
        end else begin
            if (hold_v && m_valid) begin
                check("hold_data", longint'(m_data), hold_data);
                check("hold_sat", longint'(m_sat), longint'(hold_sat));
            end
            if (m_valid && !m_ready) begin
                check("s_ready_stall", longint'(s_ready), 0);
            end
            if (m_valid && m_ready) begin
                if (sb.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_result: got %0d expected none", m_data);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    check("m_data", longint'(m_data), e.data);
                    check("m_sat", longint'(m_sat), longint'(e.sat));
                end
            end
            hold_v = m_valid && !m_ready;
            hold_data = longint'(m_data);
            hold_sat = m_sat;
        end
    end

    initial begin
        int n;
        int len;
        longint bv;
        longint ev;

        // Reset state
        repeat (3) @(posedge ap_clk);
        #1;
        check("rst_m_valid", longint'(m_valid), 0);
        check("rst_m_data", longint'(m_data), 0);
        check("rst_m_sat", longint'(m_sat), 0);
        check("rst_s_ready", longint'(s_ready), 1);
        ap_rst_n = 1'b1;
        repeat (2) @(posedge ap_clk);
        #1;

        // Single beat with latency measurement
        push_exp(65536, 1'b0);
        send_beat(65536, 65536, 1'b1);
        n = 0;
        do begin
            @(negedge ap_clk);
            n++;
        end while (!m_valid && n < 20);
        check("latency", n, 3);
        repeat (3) @(posedge ap_clk);
        #1;

        // Two back-to-back 4-beat vectors
        push_exp(655360, 1'b0);
        for (int k = 1; k <= 4; k++) send_beat(k * 65536, 65536, k == 4);
        push_exp(-262144, 1'b0);
        for (int k = 1; k <= 4; k++) send_beat(-65536, 65536, k == 4);

        // Rounding
        push_exp(2, 1'b0);
        send_beat(3, 32768, 1'b1);
        push_exp(-1, 1'b0);
        send_beat(-3, 32768, 1'b1);
        push_exp(0, 1'b0);
        send_beat(1, 32767, 1'b1);

        // Saturation
        push_exp(64'sd2147483647, 1'b1);
        for (int k = 1; k <= 4; k++) send_beat(16777215, 16777215, k == 4);
        push_exp(-64'sd2147483648, 1'b1);
        send_beat(-16777216, 16777215, 1'b1);
        repeat (5) @(posedge ap_clk);
        #1;

        // Backpressure: m_ready held low 10 cycles while 1-beat vectors stream
        fork
            begin
                rdy_mode = 2;
                repeat (10) @(posedge ap_clk);
                rdy_mode = 0;
            end
            begin
                for (int i = 0; i < 6; i++) begin
                    push_exp((i + 1) * 65536, 1'b0);
                    send_beat((i + 1) * 65536, 65536, 1'b1);
                end
            end
        join
        repeat (5) @(posedge ap_clk);
        #1;

        // Random m_ready with mixed-length vectors
        rdy_mode = 1;
        for (int i = 0; i < 8; i++) begin
            len = (i % 3) + 1;
            bv = (i % 2 == 1) ? -65536 : 65536;
            ev = len * (i + 1) * 65536;
            if (i % 2 == 1) ev = -ev;
            push_exp(ev, 1'b0);
            for (int j = 0; j < len; j++) send_beat((i + 1) * 65536, bv, j == len - 1);
        end
        n = 0;
        while (sb.size() > 0 && n < 500) begin
            @(posedge ap_clk);
            n++;
        end
        rdy_mode = 0;
        repeat (3) @(posedge ap_clk);
        #1;

        // Reset mid-vector: a held result plus two in-flight partial beats
        rdy_mode = 2;
        @(posedge ap_clk);
        #2;
        send_beat(65536, 65536, 1'b1);
        send_beat(100 * 65536, 65536, 1'b0);
        send_beat(100 * 65536, 65536, 1'b0);
        check("pre_reset_m_valid", longint'(m_valid), 1);
        ap_rst_n = 1'b0;
        #1;
        check("mid_rst_m_valid", longint'(m_valid), 0);
        check("mid_rst_m_data", longint'(m_data), 0);
        repeat (2) @(posedge ap_clk);
        rdy_mode = 0;
        #1;
        ap_rst_n = 1'b1;
        @(posedge ap_clk);
        #1;
        push_exp(65536, 1'b0);
        send_beat(65536, 65536, 1'b1);

        // Drain
        n = 0;
        while (sb.size() > 0 && n < 500) begin
            @(posedge ap_clk);
            n++;
        end
        check("drain_empty", sb.size(), 0);
        repeat (3) @(posedge ap_clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
